// File: rtl/sipo_deserializer.sv
// sipo_deserializer: collects WIDTH serial bits into a word and holds it behind a valid/ready handshake
// Ports: clk, rst (async, active-high), clr (sync clear)
//        sin/sin_valid: serial bit and its qualifier
//        dout/dout_valid/dout_ready: one-entry holding register handshake
//        busy: partial word in progress; overflow: sticky, a completed word was dropped
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;
    logic [WIDTH-1:0] sh, word;
    logic [CW-1:0] cnt;
    logic done;
    // word already includes the bit arriving this edge, so completion costs no extra cycle
    assign word = MSB_FIRST ? {sh[WIDTH-2:0], sin} : {sin, sh[WIDTH-1:1]};
    assign done = sin_valid && cnt == CW'(WIDTH - 1);
    assign dout_valid = state == FULL;
    assign busy = cnt != '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            state    <= EMPTY;
            sh       <= '0;
            cnt      <= '0;
            dout     <= '0;
            overflow <= 1'b0;
        end else begin
            if (sin_valid) begin
                sh  <= word;
                cnt <= done ? '0 : cnt + 1'b1;
            end
            case (state)
                EMPTY: if (done) begin
                    dout  <= word;
                    state <= FULL;
                end
                FULL: if (dout_ready) begin
                    if (done) dout <= word;
                    else state <= EMPTY;
                end else if (done) begin
                    overflow <= 1'b1;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: scoreboard bench driving MSB-first and LSB-first instances in parallel
module tb_sipo_deserializer;
    logic clk = 0, rst = 1, clr = 0, sin = 0, sin_valid = 0, dout_ready = 0;
    logic [3:0] dout_a, dout_b;
    logic va, vb, busy_a, busy_b, ov_a, ov_b;
    logic [3:0] qa[$], qb[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
        .dout(dout_a), .dout_valid(va), .dout_ready(dout_ready), .busy(busy_a), .overflow(ov_a));
    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
        .dout(dout_b), .dout_valid(vb), .dout_ready(dout_ready), .busy(busy_b), .overflow(ov_b));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [3:0] rev(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // first-sent bit is w[3]; the LSB-first instance therefore sees the bit-reversed word
    task automatic expect_word(input logic [3:0] w);
        qa.push_back(w);
        qb.push_back(rev(w));
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        sin_valid = 1;
        @(posedge clk); #1;
        sin_valid = 0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_all(input string n, input logic v, input logic bz, input logic ov);
        chk({n, "_valid_a"}, va, v);
        chk({n, "_valid_b"}, vb, v);
        chk({n, "_busy_a"}, busy_a, bz);
        chk({n, "_busy_b"}, busy_b, bz);
        chk({n, "_ovf_a"}, ov_a, ov);
        chk({n, "_ovf_b"}, ov_b, ov);
    endtask

    always @(negedge clk) begin
        if (!rst && !clr && dout_ready) begin
            if (va) begin
                if (qa.size() == 0) chk("unexpected_word_a", dout_a, 4'hx);
                else chk("word_a", dout_a, qa.pop_front());
            end
            if (vb) begin
                if (qb.size() == 0) chk("unexpected_word_b", dout_b, 4'hx);
                else chk("word_b", dout_b, qb.pop_front());
            end
        end
    end

    initial begin
        #2;
        chk_all("reset", 0, 0, 0);
        chk("reset_dout_a", dout_a, 0);
        tick();
        rst = 0;
        tick();
        // consecutive bits, ready held high
        dout_ready = 1;
        expect_word(4'b1011);
        send_bit(1); chk("t1_busy1", busy_a, 1);
        send_bit(0); chk("t1_busy2", busy_a, 1);
        send_bit(1); chk("t1_busy3", busy_b, 1);
        send_bit(1);
        chk_all("t1_done", 1, 0, 0);
        chk("t1_dout_a", dout_a, 4'b1011);
        chk("t2_dout_b", dout_b, 4'b1101);
        tick();
        chk("t1_valid_drop", va, 0);
        // overflow: second word dropped while holding register is full
        dout_ready = 0;
        expect_word(4'b1010);
        send_word(4'b1010);
        send_word(4'b0110);
        chk_all("t3_ovf", 1, 0, 1);
        chk("t3_dout_a", dout_a, 4'b1010);
        chk("t3_dout_b", dout_b, 4'b0101);
        dout_ready = 1;
        tick();
        dout_ready = 0;
        chk_all("t3_drain", 0, 0, 1);
        clr = 1;
        tick();
        clr = 0;
        chk_all("t3_clr", 0, 0, 0);
        // back-to-back with ready only on the completing cycle of word two
        expect_word(4'b0011);
        expect_word(4'b1100);
        send_word(4'b0011);
        send_bit(1); chk("t4_hold1", va, 1);
        send_bit(1); chk("t4_hold2", va, 1);
        send_bit(0); chk("t4_hold3", va, 1);
        dout_ready = 1;
        send_bit(0);
        dout_ready = 0;
        chk_all("t4_swap", 1, 0, 0);
        chk("t4_dout_a", dout_a, 4'b1100);
        dout_ready = 1;
        tick();
        // gapped bits with sin toggling while unqualified
        expect_word(4'b1100);
        for (int i = 0; i < 4; i++) begin
            send_bit(i < 2);
            for (int g = 0; g < i; g++) begin
                sin = ~sin;
                tick();
            end
        end
        chk("t5_dout_a", dout_a, 4'b1100);
        tick();
        // async reset mid-word
        send_bit(1);
        send_bit(0);
        chk("t6_busy_pre", busy_a, 1);
        #2 rst = 1;
        #1;
        chk_all("t6_rst", 0, 0, 0);
        chk("t6_rst_dout_a", dout_a, 0);
        @(posedge clk); #1;
        rst = 0;
        expect_word(4'b0111);
        send_word(4'b0111);
        chk("t6_dout_a", dout_a, 4'b0111);
        chk("t6_dout_b", dout_b, 4'b1110);
        tick();
        // sync clear mid-word
        send_bit(1);
        send_bit(0);
        clr = 1;
        #1;
        chk("t6_clr_pending", busy_a, 1);
        tick();
        clr = 0;
        chk_all("t6_clr", 0, 0, 0);
        chk("t6_clr_dout_a", dout_a, 0);
        expect_word(4'b0111);
        send_word(4'b0111);
        chk("t6c_dout_a", dout_a, 4'b0111);
        tick();
        tick();
        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
